apb_master_bridge: RTL and testbench
====================================

Name: apb_master_bridge

Overview:
Converts the single-request transfer interface (transfer/write/addr/wdata in; ready/rdata out) into APB bus cycles. It sits directly downstream of the request generator and upstream of the APB slaves. It performs address decode to one-hot PSEL, runs the IDLE/SETUP/ACCESS protocol, muxes PRDATA/PREADY back, and flags decode misses and wait-state timeouts on an error output.

Parameters:
NUM_SLAVES, 4, number of APB slaves, one PSEL bit each (power of 2, 1..16)
BASE_ADDR, 32'h1000_0000, base of the decoded window
SLOT_BITS, 12, log2 of bytes per slave slot (4 KB slots)
TIMEOUT, 16, max ACCESS cycles without PREADY before forced error completion (>=2)

Ports:
PCLK  in  1  clock, rising edge
PRESET  in  1  reset, asynchronous, active-high
transfer  in  1  request valid; sampled only in IDLE
write  in  1  1=write, 0=read; captured with transfer
addr  in  32  byte address; captured with transfer
wdata  in  32  write data; captured with transfer
ready  out  1  completion strobe, one cycle per request
rdata  out  32  read data, valid while ready=1 (0 for writes and errors)
error  out  1  completion with error (decode miss or timeout), valid while ready=1
PADDR  out  32  APB address
PWDATA  out  32  APB write data
PWRITE  out  1  APB direction
PENABLE  out  1  APB enable
PSEL  out  NUM_SLAVES  one-hot slave select
PRDATA  in  NUM_SLAVES*32  slave read data, slave i at [32*i +: 32]
PREADY  in  NUM_SLAVES  slave ready, bit i from slave i

Behaviour:
- Reset (async, immediate): state=IDLE; PSEL, PENABLE, PWRITE, PADDR, PWDATA, ready, rdata, error, timeout counter all 0. Reset asserted during SETUP/ACCESS drops PSEL/PENABLE at once. The request is discarded with no ready.
- FSM states: IDLE, SETUP, ACCESS.
- IDLE: on the PCLK edge with transfer=1, register addr→PADDR, wdata→PWDATA, write→PWRITE. Register the decode result (hit flag and index). Next state is SETUP. With transfer=0, stay in IDLE.
- Decode:
  - IDX_W = log2(NUM_SLAVES).
  - hit = (addr[31:SLOT_BITS+IDX_W] == BASE_ADDR[31:SLOT_BITS+IDX_W]).
  - index = addr[SLOT_BITS +: IDX_W].
  - Defaults decode 0x1000_0000–0x1000_3FFF; slave i covers 0x1000_0000 + i*0x1000.
- SETUP: PSEL[index]=1 if hit, else PSEL all 0. PENABLE=0. Unconditionally go to ACCESS next edge.
- ACCESS: PENABLE=1; PSEL held; PADDR/PWDATA/PWRITE stable throughout SETUP and ACCESS.
  - hit and PREADY[index]=1: completion this cycle.
  - hit=0 (miss): completion in the first ACCESS cycle with error=1.
  - hit and PREADY low: timeout counter increments each ACCESS cycle. When it reaches TIMEOUT-1 with PREADY still low, completion that cycle with error=1.
- Completion cycle, combinational from state/PREADY:
  - ready=1.
  - rdata = PRDATA[index] for a successful read; 0 otherwise.
  - error as above.
  - At the edge: state→IDLE, PSEL/PENABLE→0, counter→0.
- Minimum latency: transfer sampled at edge N; SETUP in cycle N+1; ACCESS with ready in cycle N+2 for a zero-wait slave. Three cycles per transfer including the IDLE return.
- Requester must drop transfer during the ready cycle. If transfer is still 1 in IDLE, a new request is accepted, which gives a back-to-back transfer with one IDLE cycle between.
- Unselected slaves' PREADY/PRDATA are ignored. PREADY glitches outside ACCESS are ignored.
- PADDR/PWDATA/PWRITE retain their last value in IDLE.

Test Plan:
- Write 0x1000_0010 ← 0xDEAD_BEEF, slave 0 PREADY tied 1 → PSEL=4'b0001 for 2 cycles; PENABLE=1 one cycle; PWRITE=1; PWDATA=0xDEAD_BEEF; ready 1 cycle, error=0, rdata=0.
- Read 0x1000_2004, slave 2 returns 0x1234_5678 after 3 wait states → PSEL=4'b0100; ACCESS lasts 4 cycles; ready coincides with PREADY[2]; rdata=0x1234_5678.
- Read 0x1000_4000 (miss) → PSEL stays 0; ready=1, error=1, rdata=0 in the 2nd cycle after acceptance.
- Read 0x1000_3000, slave 3 PREADY stuck 0 → exactly 16 ACCESS cycles; ready=1, error=1, rdata=0; back to IDLE.
- transfer held high across completion with a new addr 0x1000_1000 → second transfer to PSEL=4'b0010 starts after one IDLE cycle; PADDR stable during its SETUP/ACCESS.
- PRESET pulsed mid-ACCESS (slave 1 stalling) → PSEL, PENABLE, ready go 0 immediately without waiting for PCLK; after release, state is IDLE and the next transfer completes normally.

Source files
------------

// File: rtl/apb_master_bridge.sv
// Single-request to APB bridge: decodes the address to a one-hot PSEL, runs
// IDLE/SETUP/ACCESS, and returns read data with decode-miss/timeout errors.
module apb_master_bridge #(
    parameter int unsigned NUM_SLAVES = 4,
    parameter logic [31:0] BASE_ADDR  = 32'h1000_0000,
    parameter int unsigned SLOT_BITS  = 12,
    parameter int unsigned TIMEOUT    = 16
) (
    input  logic                     PCLK,
    input  logic                     PRESET,
    input  logic                     transfer,
    input  logic                     write,
    input  logic [31:0]              addr,
    input  logic [31:0]              wdata,
    output logic                     ready,
    output logic [31:0]              rdata,
    output logic                     error,
    output logic [31:0]              PADDR,
    output logic [31:0]              PWDATA,
    output logic                     PWRITE,
    output logic                     PENABLE,
    output logic [NUM_SLAVES-1:0]    PSEL,
    input  logic [NUM_SLAVES*32-1:0] PRDATA,
    input  logic [NUM_SLAVES-1:0]    PREADY
);

    localparam int unsigned IDX_W   = $clog2(NUM_SLAVES);
    localparam int unsigned IW      = (IDX_W > 0) ? IDX_W : 1;
    localparam int unsigned CW      = $clog2(TIMEOUT);
    localparam int unsigned DEC_LSB = SLOT_BITS + IDX_W;

    typedef enum logic [1:0] {StIdle, StSetup, StAccess} state_e;

    state_e          state_q, state_d;
    logic            hit_q;
    logic [IW-1:0]   idx_q;
    logic [CW-1:0]   cnt_q;

    logic            dec_hit;
    logic [IW-1:0]   dec_idx;
    logic            sel_ready;
    logic [31:0]     sel_rdata;
    logic            timed_out;
    logic            done;

    // Shift-based decode so a single-slave build (zero index bits) still works.
    assign dec_hit   = (addr >> DEC_LSB) == (BASE_ADDR >> DEC_LSB);
    assign dec_idx   = IW'((addr >> SLOT_BITS) & 32'(NUM_SLAVES - 1));

    assign sel_ready = PREADY[idx_q];
    assign sel_rdata = PRDATA[{idx_q, 5'd0} +: 32];
    assign timed_out = (cnt_q == CW'(TIMEOUT - 1));
    assign done      = (state_q == StAccess) && (!hit_q || sel_ready || timed_out);

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (transfer) state_d = StSetup;
            StSetup:  state_d = StAccess;
            StAccess: if (done) state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_comb begin
        PSEL    = '0;
        PENABLE = 1'b0;
        ready   = done;
        error   = 1'b0;
        rdata   = '0;
        if (state_q != StIdle && hit_q) begin
            PSEL = NUM_SLAVES'(1) << idx_q;
        end
        if (state_q == StAccess) begin
            PENABLE = 1'b1;
        end
        if (done) begin
            error = !(hit_q && sel_ready);
            if (hit_q && sel_ready && !PWRITE) begin
                rdata = sel_rdata;
            end
        end
    end

    // Request capture and wait-state counter; PADDR/PWDATA/PWRITE hold in IDLE.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            PADDR  <= '0;
            PWDATA <= '0;
            PWRITE <= 1'b0;
            hit_q  <= 1'b0;
            idx_q  <= '0;
            cnt_q  <= '0;
        end else begin
            if (state_q == StIdle && transfer) begin
                PADDR  <= addr;
                PWDATA <= wdata;
                PWRITE <= write;
                hit_q  <= dec_hit;
                idx_q  <= dec_idx;
            end
            if (state_q == StAccess && !done) begin
                cnt_q <= cnt_q + 1'b1;
            end else begin
                cnt_q <= '0;
            end
        end
    end

endmodule

// File: tb/tb_apb_master_bridge.sv
// Directed bench for apb_master_bridge: writes, wait-state reads, decode miss,
// timeout, back-to-back requests and asynchronous reset mid-transfer.
module tb_apb_master_bridge;

    logic         PCLK;
    logic         PRESET;
    logic         transfer;
    logic         write;
    logic [31:0]  addr;
    logic [31:0]  wdata;
    logic         ready;
    logic [31:0]  rdata;
    logic         error;
    logic [31:0]  PADDR;
    logic [31:0]  PWDATA;
    logic         PWRITE;
    logic         PENABLE;
    logic [3:0]   PSEL;
    logic [127:0] PRDATA;
    logic [3:0]   PREADY;

    int checks;
    int passed;

    apb_master_bridge dut (
        .PCLK     (PCLK),
        .PRESET   (PRESET),
        .transfer (transfer),
        .write    (write),
        .addr     (addr),
        .wdata    (wdata),
        .ready    (ready),
        .rdata    (rdata),
        .error    (error),
        .PADDR    (PADDR),
        .PWDATA   (PWDATA),
        .PWRITE   (PWRITE),
        .PENABLE  (PENABLE),
        .PSEL     (PSEL),
        .PRDATA   (PRDATA),
        .PREADY   (PREADY)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    task automatic test_reset();
        #1;
        checks++; if (PSEL !== 4'b0000) $display("FAIL rst_psel got %b want 0000", PSEL); else passed++;
        checks++; if (PENABLE !== 1'b0) $display("FAIL rst_penable got %b want 0", PENABLE); else passed++;
        checks++; if (ready !== 1'b0) $display("FAIL rst_ready got %b want 0", ready); else passed++;
        checks++; if (error !== 1'b0) $display("FAIL rst_error got %b want 0", error); else passed++;
        checks++; if (rdata !== 32'h0) $display("FAIL rst_rdata got %h want 0", rdata); else passed++;
        checks++; if (PADDR !== 32'h0) $display("FAIL rst_paddr got %h want 0", PADDR); else passed++;
        checks++; if (PWDATA !== 32'h0) $display("FAIL rst_pwdata got %h want 0", PWDATA); else passed++;
        checks++; if (PWRITE !== 1'b0) $display("FAIL rst_pwrite got %b want 0", PWRITE); else passed++;
        repeat (2) @(negedge PCLK);
        PRESET = 1'b0;
        @(negedge PCLK);
        checks++; if (ready !== 1'b0) $display("FAIL rst_idle_ready got %b want 0", ready); else passed++;
    endtask

    task automatic test_write();
        PREADY   = 4'b0001;
        transfer = 1'b1; write = 1'b1; addr = 32'h1000_0010; wdata = 32'hDEAD_BEEF;
        @(negedge PCLK); // SETUP
        transfer = 1'b0; addr = 32'hFFFF_FFFF; wdata = 32'h0;
        checks++; if (PSEL !== 4'b0001) $display("FAIL wr_setup_psel got %b want 0001", PSEL); else passed++;
        checks++; if (PENABLE !== 1'b0) $display("FAIL wr_setup_penable got %b want 0", PENABLE); else passed++;
        checks++; if (ready !== 1'b0) $display("FAIL wr_setup_ready got %b want 0", ready); else passed++;
        checks++; if (PWRITE !== 1'b1) $display("FAIL wr_pwrite got %b want 1", PWRITE); else passed++;
        checks++; if (PWDATA !== 32'hDEAD_BEEF) $display("FAIL wr_pwdata got %h want deadbeef", PWDATA); else passed++;
        checks++; if (PADDR !== 32'h1000_0010) $display("FAIL wr_paddr got %h want 10000010", PADDR); else passed++;
        @(negedge PCLK); // ACCESS
        checks++; if (PSEL !== 4'b0001) $display("FAIL wr_access_psel got %b want 0001", PSEL); else passed++;
        checks++; if (PENABLE !== 1'b1) $display("FAIL wr_access_penable got %b want 1", PENABLE); else passed++;
        checks++; if (ready !== 1'b1) $display("FAIL wr_ready got %b want 1", ready); else passed++;
        checks++; if (error !== 1'b0) $display("FAIL wr_error got %b want 0", error); else passed++;
        checks++; if (rdata !== 32'h0) $display("FAIL wr_rdata got %h want 0", rdata); else passed++;
        @(negedge PCLK); // IDLE
        checks++; if (PSEL !== 4'b0000) $display("FAIL wr_idle_psel got %b want 0000", PSEL); else passed++;
        checks++; if (PENABLE !== 1'b0) $display("FAIL wr_idle_penable got %b want 0", PENABLE); else passed++;
        checks++; if (ready !== 1'b0) $display("FAIL wr_idle_ready got %b want 0", ready); else passed++;
        checks++; if (PADDR !== 32'h1000_0010) $display("FAIL wr_idle_paddr got %h want 10000010", PADDR); else passed++;
    endtask

    task automatic test_wait_read();
        PREADY = 4'b0000;
        PRDATA = {32'h3333_3333, 32'h1234_5678, 32'h1111_1111, 32'h0000_0F0F};
        transfer = 1'b1; write = 1'b0; addr = 32'h1000_2004; wdata = 32'h0;
        @(negedge PCLK); // SETUP
        transfer = 1'b0;
        checks++; if (PSEL !== 4'b0100) $display("FAIL rd_setup_psel got %b want 0100", PSEL); else passed++;
        for (int k = 0; k < 4; k++) begin
            @(negedge PCLK);
            if (k == 3) PREADY = 4'b0100;
            #1;
            checks++; if (PENABLE !== 1'b1) $display("FAIL rd_access%0d_penable got %b want 1", k, PENABLE); else passed++;
            checks++; if (ready !== (k == 3)) $display("FAIL rd_access%0d_ready got %b want %b", k, ready, (k == 3)); else passed++;
        end
        checks++; if (rdata !== 32'h1234_5678) $display("FAIL rd_rdata got %h want 12345678", rdata); else passed++;
        checks++; if (error !== 1'b0) $display("FAIL rd_error got %b want 0", error); else passed++;
        checks++; if (PSEL !== 4'b0100) $display("FAIL rd_access_psel got %b want 0100", PSEL); else passed++;
        @(negedge PCLK);
        PREADY = 4'b0000;
        #1;
        checks++; if (PSEL !== 4'b0000) $display("FAIL rd_idle_psel got %b want 0000", PSEL); else passed++;
    endtask

    task automatic test_miss();
        PREADY = 4'b1111;
        transfer = 1'b1; write = 1'b0; addr = 32'h1000_4000;
        @(negedge PCLK); // SETUP
        transfer = 1'b0;
        checks++; if (PSEL !== 4'b0000) $display("FAIL miss_setup_psel got %b want 0000", PSEL); else passed++;
        checks++; if (ready !== 1'b0) $display("FAIL miss_setup_ready got %b want 0", ready); else passed++;
        @(negedge PCLK); // ACCESS
        checks++; if (PSEL !== 4'b0000) $display("FAIL miss_access_psel got %b want 0000", PSEL); else passed++;
        checks++; if (ready !== 1'b1) $display("FAIL miss_ready got %b want 1", ready); else passed++;
        checks++; if (error !== 1'b1) $display("FAIL miss_error got %b want 1", error); else passed++;
        checks++; if (rdata !== 32'h0) $display("FAIL miss_rdata got %h want 0", rdata); else passed++;
        @(negedge PCLK);
        checks++; if (ready !== 1'b0) $display("FAIL miss_idle_ready got %b want 0", ready); else passed++;
    endtask

    task automatic test_timeout();
        int cycles;
        bit seen;
        cycles = 0;
        seen   = 1'b0;
        PREADY = 4'b0111;
        transfer = 1'b1; write = 1'b0; addr = 32'h1000_3000;
        @(negedge PCLK); // SETUP
        transfer = 1'b0;
        checks++; if (PSEL !== 4'b1000) $display("FAIL to_setup_psel got %b want 1000", PSEL); else passed++;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge PCLK);
            if (PENABLE === 1'b1) cycles++;
            if (ready === 1'b1) begin
                seen = 1'b1;
                checks++; if (error !== 1'b1) $display("FAIL to_error got %b want 1", error); else passed++;
                checks++; if (rdata !== 32'h0) $display("FAIL to_rdata got %h want 0", rdata); else passed++;
                checks++; if (PSEL !== 4'b1000) $display("FAIL to_psel got %b want 1000", PSEL); else passed++;
            end
        end
        checks++; if (seen !== 1'b1) $display("FAIL to_completion got %b want 1", seen); else passed++;
        checks++; if (cycles != 16) $display("FAIL to_access_cycles got %0d want 16", cycles); else passed++;
        @(negedge PCLK);
        checks++; if (PENABLE !== 1'b0) $display("FAIL to_idle_penable got %b want 0", PENABLE); else passed++;
        checks++; if (PSEL !== 4'b0000) $display("FAIL to_idle_psel got %b want 0000", PSEL); else passed++;
        PREADY = 4'b0000;
    endtask

    task automatic test_back_to_back();
        PREADY = 4'b1111;
        PRDATA = {32'h3333_3333, 32'h2222_2222, 32'hA5A5_0001, 32'h0000_0F0F};
        transfer = 1'b1; write = 1'b0; addr = 32'h1000_0000;
        @(negedge PCLK); // SETUP
        checks++; if (PSEL !== 4'b0001) $display("FAIL b2b_first_psel got %b want 0001", PSEL); else passed++;
        @(negedge PCLK); // ACCESS
        checks++; if (ready !== 1'b1) $display("FAIL b2b_first_ready got %b want 1", ready); else passed++;
        checks++; if (rdata !== 32'h0000_0F0F) $display("FAIL b2b_first_rdata got %h want 00000f0f", rdata); else passed++;
        addr = 32'h1000_1000;
        @(negedge PCLK); // IDLE
        checks++; if (PSEL !== 4'b0000) $display("FAIL b2b_idle_psel got %b want 0000", PSEL); else passed++;
        checks++; if (ready !== 1'b0) $display("FAIL b2b_idle_ready got %b want 0", ready); else passed++;
        checks++; if (PADDR !== 32'h1000_0000) $display("FAIL b2b_idle_paddr got %h want 10000000", PADDR); else passed++;
        @(negedge PCLK); // SETUP of second
        transfer = 1'b0; addr = 32'h1000_3FFC;
        checks++; if (PSEL !== 4'b0010) $display("FAIL b2b_second_psel got %b want 0010", PSEL); else passed++;
        checks++; if (PADDR !== 32'h1000_1000) $display("FAIL b2b_setup_paddr got %h want 10001000", PADDR); else passed++;
        @(negedge PCLK); // ACCESS of second
        checks++; if (PADDR !== 32'h1000_1000) $display("FAIL b2b_access_paddr got %h want 10001000", PADDR); else passed++;
        checks++; if (ready !== 1'b1) $display("FAIL b2b_second_ready got %b want 1", ready); else passed++;
        checks++; if (rdata !== 32'hA5A5_0001) $display("FAIL b2b_second_rdata got %h want a5a50001", rdata); else passed++;
        @(negedge PCLK);
        checks++; if (PENABLE !== 1'b0) $display("FAIL b2b_end_penable got %b want 0", PENABLE); else passed++;
        PREADY = 4'b0000;
    endtask

    task automatic test_reset_mid();
        PREADY = 4'b0000;
        transfer = 1'b1; write = 1'b0; addr = 32'h1000_1000;
        @(negedge PCLK); // SETUP
        transfer = 1'b0;
        @(negedge PCLK); // ACCESS, stalled
        checks++; if (PSEL !== 4'b0010) $display("FAIL rm_access_psel got %b want 0010", PSEL); else passed++;
        checks++; if (PENABLE !== 1'b1) $display("FAIL rm_access_penable got %b want 1", PENABLE); else passed++;
        #2 PRESET = 1'b1;
        #1;
        checks++; if (PSEL !== 4'b0000) $display("FAIL rm_async_psel got %b want 0000", PSEL); else passed++;
        checks++; if (PENABLE !== 1'b0) $display("FAIL rm_async_penable got %b want 0", PENABLE); else passed++;
        checks++; if (ready !== 1'b0) $display("FAIL rm_async_ready got %b want 0", ready); else passed++;
        @(negedge PCLK);
        @(negedge PCLK);
        PRESET = 1'b0;
        PREADY = 4'b0010;
        @(negedge PCLK);
        checks++; if (ready !== 1'b0) $display("FAIL rm_post_ready got %b want 0", ready); else passed++;
        checks++; if (PSEL !== 4'b0000) $display("FAIL rm_post_psel got %b want 0000", PSEL); else passed++;
        transfer = 1'b1; write = 1'b0; addr = 32'h1000_1008;
        @(negedge PCLK); // SETUP
        transfer = 1'b0;
        checks++; if (PSEL !== 4'b0010) $display("FAIL rm_next_psel got %b want 0010", PSEL); else passed++;
        @(negedge PCLK); // ACCESS
        checks++; if (ready !== 1'b1) $display("FAIL rm_next_ready got %b want 1", ready); else passed++;
        checks++; if (error !== 1'b0) $display("FAIL rm_next_error got %b want 0", error); else passed++;
        checks++; if (rdata !== 32'hA5A5_0001) $display("FAIL rm_next_rdata got %h want a5a50001", rdata); else passed++;
        @(negedge PCLK);
        PREADY = 4'b0000;
    endtask

    initial begin
        checks   = 0;
        passed   = 0;
        PRESET   = 1'b1;
        transfer = 1'b0;
        write    = 1'b0;
        addr     = 32'h0;
        wdata    = 32'h0;
        PRDATA   = '0;
        PREADY   = 4'b0000;
        test_reset();
        test_write();
        test_wait_read();
        test_miss();
        test_timeout();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
